// File: rtl/jtag_axi_mem_slave.sv
// AXI4 responder for the JTAG debug bus: single-outstanding access to a 64-bit
// scratch memory, SLVERR for out-of-range beats and unsupported size/burst.
module jtag_axi_mem_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           ID_WIDTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1A11_0000,
  parameter int unsigned           DEPTH_WORDS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]            aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [63:0]           w_data,
  input  logic [7:0]            w_strb,
  input  logic                  w_last,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [7:0]            ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [63:0]           r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic                  r_valid,
  input  logic                  r_ready
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA} state_e;

  state_e                  state_q, state_d;
  logic                    prio_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic [8:0]              beat_q;
  logic                    ok_q;
  logic [63:0]             rdata_q;
  logic [63:0]             mem [DEPTH_WORDS];

  logic                    aw_hs, ar_hs, w_hs, last_beat;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [ADDR_WIDTH-4:0]   word_off;
  logic                    beat_in_range, beat_excess;
  logic [IDX_W-1:0]        beat_idx;

  function automatic logic unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b011) || burst[1];
  endfunction

  assign aw_hs = aw_valid && aw_ready;
  assign ar_hs = ar_valid && ar_ready;
  assign w_hs  = w_valid && w_ready;

  // FIXED repeats the start address; everything else steps one word per beat
  assign beat_addr     = (burst_q == 2'b00) ? addr_q : addr_q + ADDR_WIDTH'({beat_q, 3'b000});
  assign word_off      = beat_addr[ADDR_WIDTH-1:3] - BASE_ADDR[ADDR_WIDTH-1:3];
  assign beat_in_range = (beat_addr >= BASE_ADDR) && (word_off[ADDR_WIDTH-4:IDX_W] == '0);
  assign beat_idx      = word_off[IDX_W-1:0];
  assign beat_excess   = beat_q > {1'b0, len_q};
  assign last_beat     = beat_q == {1'b0, len_q};

  always_comb begin
    state_d  = state_q;
    aw_ready = 1'b0;
    ar_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    r_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst_i) begin
          aw_ready = !(aw_valid && ar_valid) || !prio_q;
          ar_ready = !(aw_valid && ar_valid) || prio_q;
        end
        if (aw_valid && aw_ready)      state_d = WR_DATA;
        else if (ar_valid && ar_ready) state_d = RD_WAIT;
      end
      WR_DATA: begin
        w_ready = 1'b1;
        if (w_valid && w_last) state_d = WR_RESP;
      end
      WR_RESP: begin
        b_valid = 1'b1;
        if (b_ready) state_d = IDLE;
      end
      RD_WAIT: state_d = RD_DATA;
      RD_DATA: begin
        r_valid = 1'b1;
        if (r_ready) state_d = last_beat ? IDLE : RD_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign b_id   = id_q;
  assign r_id   = id_q;
  assign b_resp = (state_q == WR_RESP && err_q) ? 2'b10 : 2'b00;
  assign r_resp = (state_q == RD_DATA && !ok_q) ? 2'b10 : 2'b00;
  assign r_last = (state_q == RD_DATA) && last_beat;
  assign r_data = (state_q == RD_DATA && ok_q) ? rdata_q : 64'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q    <= aw_id;
        addr_q  <= aw_addr;
        len_q   <= aw_len;
        burst_q <= aw_burst;
        err_q   <= unsupported(aw_size, aw_burst);
        beat_q  <= '0;
        prio_q  <= ~prio_q;
      end else if (ar_hs) begin
        id_q    <= ar_id;
        addr_q  <= ar_addr;
        len_q   <= ar_len;
        burst_q <= ar_burst;
        err_q   <= unsupported(ar_size, ar_burst);
        beat_q  <= '0;
        prio_q  <= ~prio_q;
      end
      // error is sticky across the burst; the counter saturates on runaway bursts
      if (w_hs) begin
        err_q <= err_q | ~beat_in_range | beat_excess | (w_last && !last_beat);
        if (beat_q != '1) beat_q <= beat_q + 9'd1;
      end
      if (state_q == RD_WAIT) ok_q <= !err_q && beat_in_range;
      if (state_q == RD_DATA && r_ready && !last_beat) beat_q <= beat_q + 9'd1;
    end
  end

  // memory and read word are data only, never reset
  always_ff @(posedge clk_i) begin
    if (w_hs && !err_q && !beat_excess && beat_in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (w_strb[b]) mem[beat_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
    if (state_q == RD_WAIT) rdata_q <= mem[beat_idx];
  end

endmodule

// File: tb/tb_jtag_axi_mem_slave.sv
// Directed plus randomized bench for jtag_axi_mem_slave against a word-array model.
module tb_jtag_axi_mem_slave;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1A11_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  aw_id = '0, ar_id = '0, b_id, r_id;
  logic [31:0] aw_addr = '0, ar_addr = '0;
  logic [7:0]  aw_len = '0, ar_len = '0, w_strb = '0;
  logic [2:0]  aw_size = '0, ar_size = '0;
  logic [1:0]  aw_burst = '0, ar_burst = '0, b_resp, r_resp;
  logic        aw_valid = 1'b0, ar_valid = 1'b0, w_valid = 1'b0, w_last = 1'b0;
  logic        b_ready = 1'b0, r_ready = 1'b0;
  logic        aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last;
  logic [63:0] w_data = '0, r_data;

  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] mem_m [DEPTH];
  logic [63:0] wq [256];
  logic [7:0]  sq [256];

  jtag_axi_mem_slave dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  function automatic logic [31:0] beat_a(input logic [31:0] a0, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a0 : a0 + 32'(8 * i);
  endfunction

  task automatic model_write(input logic [31:0] a0, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input int nb, output logic [1:0] resp);
    bit err;
    logic [31:0] a;
    err = (size != 3'b011) || (burst >= 2'b10);
    for (int i = 0; i < nb; i++) begin
      a = beat_a(a0, burst, i);
      if (i > len || !in_rng(a)) err = 1'b1;
      else if (!err)
        for (int b = 0; b < 8; b++)
          if (sq[i][b]) mem_m[widx(a)][8*b +: 8] = wq[i][8*b +: 8];
    end
    if (nb != len + 1) err = 1'b1;
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    aw_id = id; aw_addr = a; aw_len = 8'(len); aw_size = size; aw_burst = burst; aw_valid = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    ar_id = id; ar_addr = a; ar_len = 8'(len); ar_size = size; ar_burst = burst; ar_valid = 1'b1;
  endtask

  task automatic aw_hs();
    int n = 0;
    #1;
    while (!aw_ready && n < 50) begin @(negedge clk_i); #1; n++; end
    check("aw_ready", aw_ready, 1);
    @(negedge clk_i);
    aw_valid = 1'b0;
  endtask

  task automatic ar_hs();
    int n = 0;
    #1;
    while (!ar_ready && n < 50) begin @(negedge clk_i); #1; n++; end
    check("ar_ready", ar_ready, 1);
    @(negedge clk_i);
    ar_valid = 1'b0;
  endtask

  task automatic w_phase(input int nb);
    int n;
    for (int i = 0; i < nb; i++) begin
      w_data = wq[i]; w_strb = sq[i]; w_last = (i == nb - 1); w_valid = 1'b1;
      n = 0;
      #1;
      while (!w_ready && n < 50) begin @(negedge clk_i); #1; n++; end
      check("w_ready", w_ready, 1);
      @(negedge clk_i);
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic b_phase(input logic [3:0] id, input logic [1:0] resp, input int hold);
    int n = 0;
    while (!b_valid && n < 50) begin @(negedge clk_i); n++; end
    check("b_valid", b_valid, 1);
    repeat (hold) begin
      check("b_hold_valid", b_valid, 1);
      check("b_hold_resp", b_resp, resp);
      @(negedge clk_i);
    end
    check("b_resp", b_resp, resp);
    check("b_id", b_id, id);
    b_ready = 1'b1;
    @(negedge clk_i);
    b_ready = 1'b0;
  endtask

  task automatic r_phase(input logic [3:0] id, input logic [31:0] a0, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input int hold);
    bit aerr, ok;
    int n;
    logic [31:0] a;
    logic [63:0] ed;
    aerr = (size != 3'b011) || (burst >= 2'b10);
    for (int i = 0; i <= len; i++) begin
      a  = beat_a(a0, burst, i);
      ok = !aerr && in_rng(a);
      ed = 64'h0;
      if (ok) ed = mem_m[widx(a)];
      n = 1;
      while (!r_valid && n < 50) begin @(negedge clk_i); n++; end
      check("r_valid", r_valid, 1);
      check("r_latency", n, 2);
      if (i == 0) begin
        repeat (hold) begin
          check("r_hold_valid", r_valid, 1);
          check("r_hold_data", r_data, ed);
          @(negedge clk_i);
        end
      end
      check("r_data", r_data, ed);
      check("r_resp", r_resp, ok ? 2'b00 : 2'b10);
      check("r_last", r_last, i == len);
      check("r_id", r_id, id);
      r_ready = 1'b1;
      @(negedge clk_i);
      r_ready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int nb, input int hold);
    logic [1:0] er;
    model_write(a, len, size, burst, nb, er);
    set_aw(id, a, len, size, burst);
    aw_hs();
    w_phase(nb);
    b_phase(id, er, hold);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input int hold);
    set_ar(id, a, len, size, burst);
    ar_hs();
    r_phase(id, a, len, size, burst, hold);
  endtask

  initial begin
    logic [1:0]  er;
    logic [31:0] a;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          len, nb, k;

    repeat (3) @(negedge clk_i);
    check("rst_aw_ready", aw_ready, 0);
    check("rst_ar_ready", ar_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_resp_last", {b_resp, r_resp, r_last}, 0);
    check("rst_r_data", r_data, 0);
    check("rst_ids", {b_id, r_id}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // simultaneous AW/AR twice: write wins first, then read
    wq[0] = 64'hDEAD_BEEF_0123_4567; sq[0] = 8'hFF;
    model_write(BASE, 0, 3'b011, 2'b01, 1, er);
    set_aw(4'h3, BASE, 0, 3'b011, 2'b01);
    set_ar(4'h5, BASE, 0, 3'b011, 2'b01);
    #1;
    check("arb1_aw_ready", aw_ready, 1);
    check("arb1_ar_ready", ar_ready, 0);
    aw_hs();
    check("w_ready_latency", w_ready, 1);
    check("ar_blocked", ar_ready, 0);
    w_phase(1);
    check("b_valid_latency", b_valid, 1);
    b_phase(4'h3, er, 0);
    set_aw(4'h6, BASE, 0, 3'b011, 2'b01);
    #1;
    check("arb2_ar_ready", ar_ready, 1);
    check("arb2_aw_ready", aw_ready, 0);
    ar_hs();
    r_phase(4'h5, BASE, 0, 3'b011, 2'b01, 0);
    model_write(BASE, 0, 3'b011, 2'b01, 1, er);
    aw_hs();
    w_phase(1);
    b_phase(4'h6, er, 0);

    // fill whole memory so every later read has a known expectation
    for (int i = 0; i < 256; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'hFF; end
    wq[0] = 64'hDEAD_BEEF_0123_4567;
    do_write(4'h1, BASE, 255, 3'b011, 2'b01, 256, 0);
    do_read(4'h1, BASE, 0, 3'b011, 2'b01, 0);

    wq[0] = '1; sq[0] = 8'hFF;
    do_write(4'h2, BASE + 32'd40, 0, 3'b011, 2'b01, 1, 0);
    wq[0] = 64'h1111_1111_2222_2222; sq[0] = 8'h0F;
    do_write(4'h2, BASE + 32'd40, 0, 3'b011, 2'b01, 1, 0);
    do_read(4'h2, BASE + 32'd40, 0, 3'b011, 2'b01, 0);

    // burst crossing the top of the memory
    for (int i = 0; i < 4; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'hFF; end
    do_write(4'h7, BASE + 32'(8 * (DEPTH - 2)), 3, 3'b011, 2'b01, 4, 0);
    do_read(4'h8, BASE + 32'(8 * (DEPTH - 2)), 3, 3'b011, 2'b01, 0);

    // unsupported size and WRAP/reserved bursts
    wq[0] = {$urandom, $urandom}; wq[1] = {$urandom, $urandom}; sq[0] = 8'hFF; sq[1] = 8'hFF;
    do_write(4'h9, BASE + 32'd80, 0, 3'b010, 2'b01, 1, 0);
    do_write(4'hA, BASE + 32'd88, 1, 3'b011, 2'b10, 2, 0);
    do_write(4'hB, BASE + 32'd88, 0, 3'b011, 2'b11, 1, 0);
    do_read(4'h9, BASE + 32'd80, 1, 3'b010, 2'b01, 0);
    do_read(4'hA, BASE + 32'd80, 1, 3'b011, 2'b10, 0);
    do_read(4'hB, BASE + 32'd80, 1, 3'b011, 2'b01, 0);

    // FIXED burst, short burst, overlong burst, backpressure hold
    for (int i = 0; i < 5; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'(1 << i) | 8'h80; end
    do_write(4'hC, BASE + 32'd56, 2, 3'b011, 2'b00, 3, 0);
    do_read(4'hC, BASE + 32'd56, 2, 3'b011, 2'b00, 0);
    do_write(4'hD, BASE + 32'd160, 3, 3'b011, 2'b01, 2, 0);
    do_write(4'hE, BASE + 32'd192, 1, 3'b011, 2'b01, 4, 5);
    do_read(4'hD, BASE + 32'd160, 7, 3'b011, 2'b01, 5);

    w_data = '1; w_strb = 8'hFF; w_last = 1'b1; w_valid = 1'b1;
    #1;
    check("idle_w_ready", w_ready, 0);
    @(negedge clk_i);
    w_valid = 1'b0; w_last = 1'b0;

    for (int t = 0; t < 40; t++) begin
      k = int'($urandom_range(0, DEPTH + 7)) - 4;
      a = BASE + 32'(k * 8);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 7));
      len   = int'($urandom_range(0, 5));
      size  = ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b011;
      burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        nb = len + 1;
        if ($urandom_range(0, 5) == 0) nb = nb + 1;
        else if ($urandom_range(0, 5) == 0 && len > 0) nb = nb - 1;
        for (int i = 0; i < nb; i++) begin wq[i] = {$urandom, $urandom}; sq[i] = 8'($urandom); end
        do_write(4'($urandom), a, len, size, burst, nb, 0);
      end else begin
        do_read(4'($urandom), a, len, size, burst, 0);
      end
    end

    // reset in the middle of a read burst
    set_ar(4'h4, BASE, 3, 3'b011, 2'b01);
    ar_hs();
    @(negedge clk_i);
    check("pre_rst_r_valid", r_valid, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_r_valid", r_valid, 0);
    check("mid_rst_r_data", r_data, 0);
    check("mid_rst_readies", {aw_ready, ar_ready, w_ready}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("post_rst_idle", {aw_ready, ar_ready, w_ready, b_valid, r_valid}, 5'b11000);
    set_aw(4'h1, BASE, 0, 3'b011, 2'b01);
    set_ar(4'h1, BASE, 0, 3'b011, 2'b01);
    #1;
    check("post_rst_prio", {aw_ready, ar_ready}, 2'b10);
    aw_valid = 1'b0; ar_valid = 1'b0;
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
